// File: rtl/fifo_get_controller.sv
//------------------------------------------------------------------------------
// fifo_get_controller: get-side token ring of a mixed-clock cell FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_get_controller #(
  parameter int NCELLS = 4,
  parameter int WIDTH  = 8
) (
  input  logic                      clk_get,
  input  logic                      reset,
  input  logic                      req_get,
  input  logic [NCELLS-1:0]         cell_full,
  input  logic [NCELLS*WIDTH-1:0]   cell_data,
  input  logic [NCELLS-1:0]         gtok_hold,
  output logic [NCELLS-1:0]         en_get,
  output logic [NCELLS-1:0]         gtok,
  output logic [WIDTH-1:0]          data_get,
  output logic                      valid_get,
  output logic                      empty
);

  localparam logic [NCELLS-1:0] TOK_RESET = {{(NCELLS-1){1'b0}}, 1'b1};

  logic [NCELLS-1:0] sync1_q;
  logic [NCELLS-1:0] full_s_q;
  logic [NCELLS-1:0] consumed_q, consumed_d;
  logic [NCELLS-1:0] gtok_q, gtok_d;
  logic [NCELLS-1:0] ready;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  tok_word;
  logic              valid_q, valid_d;
  logic              deq;

  // A consumed cell stays blocked until its synchronized full flag drops,
  // so a stale high flag cannot cause a second read of the same word.
  assign ready  = full_s_q & ~consumed_q & ~gtok_hold;
  assign empty  = ~|(gtok_q & ready);
  assign deq    = req_get & ~empty;
  assign en_get = deq ? gtok_q : '0;

  always_comb begin
    tok_word = '0;
    for (int i = 0; i < NCELLS; i++) begin
      if (gtok_q[i]) begin
        tok_word = tok_word | cell_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    consumed_d = (consumed_q & full_s_q) | en_get;
    gtok_d     = deq ? {gtok_q[NCELLS-2:0], gtok_q[NCELLS-1]} : gtok_q;
    data_d     = deq ? tok_word : data_q;
    valid_d    = deq;
  end

  always_ff @(posedge clk_get or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      full_s_q   <= '0;
      consumed_q <= '0;
      gtok_q     <= TOK_RESET;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= cell_full;
      full_s_q   <= sync1_q;
      consumed_q <= consumed_d;
      gtok_q     <= gtok_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign gtok      = gtok_q;
  assign data_get  = data_q;
  assign valid_get = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_get_controller.sv
//------------------------------------------------------------------------------
// tb_fifo_get_controller: directed scenarios plus random traffic vs. a model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_get_controller;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk_get = 1'b0;
  logic             reset;
  logic             req_get;
  logic [N-1:0]     cell_full;
  logic [N*W-1:0]   cell_data;
  logic [N-1:0]     gtok_hold;
  logic [N-1:0]     en_get;
  logic [N-1:0]     gtok;
  logic [W-1:0]     data_get;
  logic             valid_get;
  logic             empty;

  int errors = 0;
  int checks = 0;

  // Model: token as an index, synchronizer as a two-deep history of cell_full,
  // and a per-cell "read since last seen low" flag.
  int           m_tok;
  logic [N-1:0] m_s1, m_fs, m_rd;
  logic         m_valid;
  logic [W-1:0] m_data;

  fifo_get_controller #(.NCELLS(N), .WIDTH(W)) dut (
    .clk_get   (clk_get),
    .reset     (reset),
    .req_get   (req_get),
    .cell_full (cell_full),
    .cell_data (cell_data),
    .gtok_hold (gtok_hold),
    .en_get    (en_get),
    .gtok      (gtok),
    .data_get  (data_get),
    .valid_get (valid_get),
    .empty     (empty)
  );

  always #5 clk_get = ~clk_get;

  task automatic model_reset();
    m_tok   = 0;
    m_s1    = '0;
    m_fs    = '0;
    m_rd    = '0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next
  // falling edge after one rising edge has been checked against the model.
  task automatic run_cycle();
    logic         rdy, can, exp_empty;
    logic [N-1:0] exp_en, exp_tok;
    #1;
    rdy       = m_fs[m_tok] && !m_rd[m_tok] && !gtok_hold[m_tok];
    exp_empty = !rdy;
    can       = req_get && rdy;
    exp_en    = '0;
    if (can) exp_en[m_tok] = 1'b1;
    checks++;
    if (en_get !== exp_en) begin
      errors++;
      $display("FAIL model_en_get t=%0t got=%b exp=%b", $time, en_get, exp_en);
    end
    checks++;
    if (empty !== exp_empty) begin
      errors++;
      $display("FAIL model_empty t=%0t got=%b exp=%b", $time, empty, exp_empty);
    end
    @(posedge clk_get);
    for (int i = 0; i < N; i++) if (!m_fs[i]) m_rd[i] = 1'b0;
    if (can) begin
      m_data      = cell_data[m_tok*W +: W];
      m_valid     = 1'b1;
      m_rd[m_tok] = 1'b1;
      m_tok       = (m_tok + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
    m_fs = m_s1;
    m_s1 = cell_full;
    exp_tok = '0;
    exp_tok[m_tok] = 1'b1;
    #1;
    checks++;
    if (valid_get !== m_valid) begin
      errors++;
      $display("FAIL model_valid t=%0t got=%b exp=%b", $time, valid_get, m_valid);
    end
    checks++;
    if (data_get !== m_data) begin
      errors++;
      $display("FAIL model_data t=%0t got=%h exp=%h", $time, data_get, m_data);
    end
    checks++;
    if (gtok !== exp_tok) begin
      errors++;
      $display("FAIL model_gtok t=%0t got=%b exp=%b", $time, gtok, exp_tok);
    end
    @(negedge clk_get);
  endtask

  task automatic apply_reset();
    @(negedge clk_get);
    reset = 1'b1;
    model_reset();
    @(negedge clk_get);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_get);
    reset     = 1'b1;
    cell_full = '1;
    gtok_hold = '0;
    req_get   = 1'b1;
    model_reset();
    #1;
    checks++;
    if (en_get !== 4'b0000 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb en_get=%b empty=%b exp en_get=0000 empty=1", en_get, empty);
    end
    checks++;
    if (gtok !== 4'b0001 || valid_get !== 1'b0 || data_get !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs gtok=%b valid=%b data=%h exp 0001/0/00", gtok, valid_get, data_get);
    end
    @(negedge clk_get);
    reset = 1'b0;
  endtask

  task automatic test_first_read();
    apply_reset();
    cell_full = 4'b0001;
    cell_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    gtok_hold = '0;
    req_get   = 1'b1;
    run_cycle();
    checks++;
    if (en_get !== 4'b0000) begin
      errors++;
      $display("FAIL first_too_early en_get=%b exp=0000", en_get);
    end
    run_cycle();
    checks++;
    if (en_get !== 4'b0001) begin
      errors++;
      $display("FAIL first_en_3rd_edge en_get=%b exp=0001", en_get);
    end
    run_cycle();
    checks++;
    if (data_get !== 8'hA5 || valid_get !== 1'b1 || gtok !== 4'b0010) begin
      errors++;
      $display("FAIL first_result data=%h valid=%b gtok=%b exp A5/1/0010", data_get, valid_get, gtok);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got[$];
    logic [W-1:0] want[$];
    want = '{8'h10, 8'h11, 8'h12, 8'h13};
    apply_reset();
    cell_full = 4'b1111;
    cell_data = {8'h13, 8'h12, 8'h11, 8'h10};
    gtok_hold = '0;
    req_get   = 1'b1;
    for (int c = 0; c < 7; c++) begin
      run_cycle();
      if (valid_get === 1'b1) got.push_back(data_get);
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL burst_data got=%p exp=%p", got, want);
    end
    checks++;
    if (gtok !== 4'b0001 || empty !== 1'b1) begin
      errors++;
      $display("FAIL burst_wrap gtok=%b empty=%b exp 0001/1", gtok, empty);
    end
  endtask

  // Continues from the burst: cell 0 flag stays high but its word is spent.
  task automatic test_stale_flag();
    int  reads0;
    bit  seen;
    reads0 = 0;
    for (int c = 0; c < 6; c++) begin
      run_cycle();
      if (en_get[0] === 1'b1) reads0++;
    end
    checks++;
    if (reads0 != 0) begin
      errors++;
      $display("FAIL stale_double_read count=%0d exp=0", reads0);
    end
    cell_full[0] = 1'b0;
    for (int c = 0; c < 3; c++) run_cycle();
    cell_full[0] = 1'b1;
    cell_data[7:0] = 8'h5A;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      run_cycle();
      if (en_get[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stale_refill_timeout en_get0=%b exp=1", en_get[0]);
    end
    run_cycle();
  endtask

  task automatic test_hold();
    bit reached;
    apply_reset();
    cell_full = 4'b0111;
    cell_data = {8'h44, 8'h33, 8'h22, 8'h11};
    gtok_hold = 4'b0100;
    req_get   = 1'b1;
    reached   = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      run_cycle();
      if (gtok === 4'b0100) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL hold_token_timeout gtok=%b exp=0100", gtok);
    end
    run_cycle();
    checks++;
    if (en_get !== 4'b0000 || empty !== 1'b1) begin
      errors++;
      $display("FAIL hold_stall en_get=%b empty=%b exp 0000/1", en_get, empty);
    end
    gtok_hold = 4'b0000;
    #1;
    checks++;
    if (en_get !== 4'b0100) begin
      errors++;
      $display("FAIL hold_release en_get=%b exp=0100", en_get);
    end
    run_cycle();
    checks++;
    if (data_get !== 8'h33 || gtok !== 4'b1000) begin
      errors++;
      $display("FAIL hold_read data=%h gtok=%b exp 33/1000", data_get, gtok);
    end
  endtask

  task automatic test_async_reset();
    bit reached;
    apply_reset();
    cell_full = 4'b0011;
    cell_data = {8'h00, 8'h00, 8'hB2, 8'hB1};
    gtok_hold = '0;
    req_get   = 1'b1;
    reached   = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      run_cycle();
      if (en_get === 4'b0010) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL async_setup_timeout en_get=%b exp=0010", en_get);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (en_get !== 4'b0000 || gtok !== 4'b0001 || valid_get !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset en_get=%b gtok=%b valid=%b empty=%b exp 0000/0001/0/1",
               en_get, gtok, valid_get, empty);
    end
    model_reset();
    @(negedge clk_get);
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    apply_reset();
    cell_full = 4'b1111;
    cell_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    gtok_hold = '0;
    req_get   = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      if (en_get !== 4'b0000 || gtok !== 4'b0001 || valid_get !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_no_grant bad_cycles=%0d exp=0 gtok=%b", bad, gtok);
    end
  endtask

  task automatic test_random();
    apply_reset();
    cell_full = '0;
    gtok_hold = '0;
    req_get   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) cell_full[i] = ~cell_full[i];
        gtok_hold[i] = ($urandom_range(7) == 0);
      end
      cell_data = {$urandom(), $urandom()} >> 32;
      req_get   = ($urandom_range(3) != 0);
      run_cycle();
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_get   = 1'b0;
    cell_full = '0;
    cell_data = '0;
    gtok_hold = '0;
    model_reset();
    test_reset();
    test_first_read();
    test_back_to_back();
    test_stale_flag();
    test_hold();
    test_async_reset();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fifo_get_controller.md
FIFO_GET_CONTROLLER -- requirements
Module: fifo_get_controller

Interface
REQ-001 SHALL have parameter NCELLS, default 4, giving the number of FIFO cells in the ring (legal range 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, giving the data width per cell.
REQ-003 SHALL have port clk_get, input, 1 bit: the single get-domain clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_get, input, 1 bit: the consumer requests one word.
REQ-006 SHALL have port cell_full, input, NCELLS bits: per-cell full flags, asynchronous to clk_get.
REQ-007 SHALL have port cell_data, input, NCELLS*WIDTH bits: per-cell data, with cell i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port gtok_hold, input, NCELLS bits: per-cell collision hold; while it is high the token SHALL NOT dequeue that cell.
REQ-009 SHALL have port en_get, output, NCELLS bits: one-hot or zero dequeue strobe to the cells.
REQ-010 SHALL have port gtok, output, NCELLS bits: one-hot get-token position.
REQ-011 SHALL have port data_get, output, WIDTH bits: registered dequeued word.
REQ-012 SHALL have port valid_get, output, 1 bit: data_get holds a word dequeued on the previous edge.
REQ-013 SHALL have port empty, output, 1 bit: the token cell cannot be dequeued this cycle.

Function
REQ-014 SHALL pass each cell_full bit through a 2-flop synchronizer clocked by clk_get, producing full_s.
REQ-015 SHALL keep an NCELLS-bit consumed mask; bit i SHALL be set on an edge where cell i is dequeued, and cleared on an edge where full_s[i]==0 (clear wins only when no dequeue of i occurs on that edge).
REQ-016 SHALL define ready[i] = full_s[i] & ~consumed[i] & ~gtok_hold[i].
REQ-017 SHALL drive empty = ~|(gtok & ready), combinationally from registers and gtok_hold.
REQ-018 SHALL drive en_get = gtok when req_get & ~empty, and all-zero otherwise (combinational, same cycle).
REQ-019 On an edge with en_get != 0, SHALL load data_get <= cell_data slice of the token cell, set valid_get <= 1, and rotate gtok one position upward (bit NCELLS-1 wraps to bit 0).
REQ-020 On an edge with en_get == 0, SHALL set valid_get <= 0, hold data_get, and hold gtok.
REQ-021 SHALL keep gtok one-hot at all times; it SHALL never advance past a cell that is not ready.
REQ-022 Throughput: one word per clk_get cycle while consecutive token cells are ready; read latency is 1 cycle (en_get edge to valid_get high).
REQ-023 A cell dequeued on edge N SHALL NOT be dequeued again until full_s for that cell has been observed low and then high again (no double-read from a stale synchronized flag).
REQ-024 When req_get is high with empty high, SHALL produce no en_get, hold the token, and leave the request ungranted with no error state.
REQ-025 gtok_hold high on the token cell SHALL stall the ring exactly as if that cell were empty.

Reset
REQ-026 Asserting reset SHALL immediately force: gtok = 1 (cell 0), consumed = 0, synchronizer flops = 0, data_get = 0, valid_get = 0.
REQ-027 Consequently during reset SHALL hold en_get = 0 and empty = 1; reset asserted mid-dequeue SHALL abort it with no partial state retained.
REQ-028 After deassertion, the first dequeue SHALL NOT occur before 2 clk_get edges, the synchronizer latency.

Verification
REQ-029 Reset, then cell_full=4'b0001, cell0 data=8'hA5, req_get=1 -> en_get=4'b0001 on the 3rd edge; next cycle data_get=8'hA5, valid_get=1, gtok=4'b0010.
REQ-030 All cells full, data 8'h10..8'h13, req_get held high -> four consecutive valid_get cycles with data 10,11,12,13; gtok wraps to 4'b0001; empty=1 afterwards.
REQ-031 After cell0 is dequeued, hold cell_full[0]=1 (stale) while the token returns to cell 0 -> no second en_get[0] until cell_full[0] goes 0 then 1.
REQ-032 Token at cell 2, cell 2 full, gtok_hold[2]=1, req_get=1 -> en_get=0 and empty=1; release hold -> en_get=4'b0100 in the same cycle.
REQ-033 Reset asserted asynchronously between edges while en_get=4'b0010 -> en_get=0, gtok=4'b0001, valid_get=0 immediately, before the next edge.
REQ-034 req_get=0 with all cells full for 10 cycles -> en_get=0 throughout, gtok unchanged, valid_get=0.
